// File: rtl/jogo_mindfocus_param_if.sv
// jogo_mindfocus_param_if: control, button and status bundle between the board wrapper and the game core
interface jogo_mindfocus_param_if #(
    parameter int IDX_W   = 2,
    parameter int SEQ_LEN = 4
);
    logic                     iniciar;
    logic                     modo;
    logic [2**IDX_W-1:0]      botoes;
    logic                     pronto;
    logic [3:0]               acertos;
    logic [3:0]               rodada;
    logic [SEQ_LEN*IDX_W-1:0] indices;
    logic [IDX_W-1:0]         db_jogada;
    logic                     db_timeout;
    logic [3:0]               db_estado;
    modport master (
        output iniciar, modo, botoes,
        input  pronto, acertos, rodada, indices, db_jogada, db_timeout, db_estado
    );
    modport slave (
        input  iniciar, modo, botoes,
        output pronto, acertos, rodada, indices, db_jogada, db_timeout, db_estado
    );
endinterface

// File: rtl/jogo_mindfocus_param.sv
// jogo_mindfocus_param: LFSR-generated target sequence game, one button press scored per round
module jogo_mindfocus_param #(
    parameter int         IDX_W   = 2,
    parameter int         SEQ_LEN = 4,
    parameter int         TIMEOUT = 1000,
    parameter logic [7:0] SEED    = 8'hA5
) (
    input logic                clock,
    input logic                reset,
    jogo_mindfocus_param_if.slave io
);
    localparam int N  = 2**IDX_W;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        INICIAL  = 4'h0,
        GERA     = 4'h1,
        ESPERA   = 4'h2,
        REGISTRA = 4'h3,
        COMPARA  = 4'h4,
        PROXIMA  = 4'h5,
        SOLTA    = 4'h6,
        FIM      = 4'hF
    } estado_t;

    estado_t                  estado, proximo;
    logic [7:0]               lfsr;
    logic [SEQ_LEN*IDX_W-1:0] idx;
    logic [3:0]               gen, acertos, rodada;
    logic [TW-1:0]            timer;
    logic [N-1:0]             jogada;
    logic [IDX_W-1:0]         db_jogada, cod;
    logic                     modo_l, db_timeout, hit, expira, ultima;

    always_comb begin
        cod = '0;
        for (int i = N - 1; i >= 0; i--)
            if (io.botoes[i]) cod = IDX_W'(i);
    end

    assign expira = timer == TW'(TIMEOUT - 1);
    assign ultima = rodada == 4'(SEQ_LEN - 1);
    assign hit    = jogada != '0 && (jogada & (jogada - 1'b1)) == '0 &&
                    db_jogada == idx[rodada*IDX_W +: IDX_W];

    always_ff @(posedge clock) begin
        if (!reset) estado <= INICIAL;
        else        estado <= proximo;
    end

    // a button on the timeout cycle takes priority over the timeout
    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:  if (io.iniciar) proximo = GERA;
            GERA:     if (gen == 4'(SEQ_LEN - 1)) proximo = ESPERA;
            ESPERA:   proximo = io.botoes != '0 ? REGISTRA : expira ? PROXIMA : ESPERA;
            REGISTRA: proximo = COMPARA;
            COMPARA:  proximo = (hit || !modo_l) ? PROXIMA : FIM;
            PROXIMA:  proximo = ultima ? FIM : SOLTA;
            SOLTA:    if (io.botoes == '0) proximo = ESPERA;
            FIM:      if (io.iniciar) proximo = GERA;
            default:  proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr       <= SEED;
            idx        <= '0;
            gen        <= '0;
            timer      <= '0;
            acertos    <= '0;
            rodada     <= '0;
            jogada     <= '0;
            db_jogada  <= '0;
            modo_l     <= 1'b0;
            db_timeout <= 1'b0;
        end else begin
            db_timeout <= estado == ESPERA && io.botoes == '0 && expira;
            timer      <= estado == ESPERA ? timer + 1'b1 : '0;
            if (proximo == GERA && estado != GERA) begin
                acertos <= '0;
                rodada  <= '0;
                gen     <= '0;
                modo_l  <= io.modo;
            end
            // Galois step for x^8+x^6+x^5+x^4+1; the LFSR is never reseeded between games
            if (estado == GERA) begin
                idx[gen*IDX_W +: IDX_W] <= lfsr[IDX_W-1:0];
                lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
                gen  <= gen + 1'b1;
            end
            if (estado == REGISTRA) begin
                jogada    <= io.botoes;
                db_jogada <= cod;
            end
            if (estado == COMPARA && hit && acertos != 4'(SEQ_LEN)) acertos <= acertos + 1'b1;
            if (estado == PROXIMA && !ultima) rodada <= rodada + 1'b1;
        end
    end

    assign io.pronto     = estado == FIM;
    assign io.acertos    = acertos;
    assign io.rodada     = rodada;
    assign io.indices    = idx;
    assign io.db_jogada  = db_jogada;
    assign io.db_timeout = db_timeout;
    assign io.db_estado  = estado;
endmodule

// File: tb/tb_jogo_mindfocus_param.sv
// tb_jogo_mindfocus_param: scoreboard bench for the mindfocus game core with default parameters
module tb_jogo_mindfocus_param;
    localparam int IDX_W   = 2;
    localparam int SEQ_LEN = 4;
    localparam int TIMEOUT = 1000;
    localparam int N       = 2**IDX_W;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    jogo_mindfocus_param_if #(.IDX_W(IDX_W), .SEQ_LEN(SEQ_LEN)) io();

    jogo_mindfocus_param #(
        .IDX_W(IDX_W), .SEQ_LEN(SEQ_LEN), .TIMEOUT(TIMEOUT), .SEED(8'hA5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io(io)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]       acertos;
        logic [IDX_W-1:0] jogada;
        logic [3:0]       estado;
    } exp_t;

    exp_t                     sb[$];
    logic [7:0]               m_lfsr;
    logic [SEQ_LEN*IDX_W-1:0] m_idx;
    int                       m_acertos, m_rodada;
    bit                       m_modo;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    function automatic logic [N-1:0] onehot_of(input logic [IDX_W-1:0] v);
        logic [N-1:0] r;
        r = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] target(input int k);
        return m_idx[k*IDX_W +: IDX_W];
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_state(input logic [3:0] code, input int budget);
        int k = 0;
        while (io.db_estado !== code && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (io.db_estado !== code) begin
            errors++;
            $display("FAIL wait_state: db_estado=%h required %h", io.db_estado, code);
        end
    endtask

    task automatic start_game(input bit m);
        io.modo = m;
        io.iniciar = 1'b1;
        step();
        io.iniciar = 1'b0;
        checks++;
        if (io.db_estado !== 4'h1) begin errors++; $display("FAIL start_state: db_estado=%h required 1", io.db_estado); end
        checks++;
        if (io.acertos !== 4'd0) begin errors++; $display("FAIL start_acertos: got %0d required 0", io.acertos); end
        m_idx = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            m_idx[k*IDX_W +: IDX_W] = m_lfsr[IDX_W-1:0];
            m_lfsr = lfsr_step(m_lfsr);
        end
        m_acertos = 0;
        m_rodada  = 0;
        m_modo    = m;
        step(SEQ_LEN - 1);
        checks++;
        if (io.db_estado !== 4'h1) begin errors++; $display("FAIL gera_length: db_estado=%h required 1", io.db_estado); end
        step();
        checks++;
        if (io.db_estado !== 4'h2) begin errors++; $display("FAIL gera_done: db_estado=%h required 2", io.db_estado); end
        checks++;
        if (io.indices !== m_idx) begin errors++; $display("FAIL indices: got %h required %h", io.indices, m_idx); end
    endtask

    task automatic press(input logic [N-1:0] b, input bit hold);
        exp_t             e;
        logic [IDX_W-1:0] enc;
        bit               hit;
        wait_state(4'h2, 50);
        io.botoes = b;
        enc = '0;
        for (int i = N - 1; i >= 0; i--)
            if (b[i]) enc = IDX_W'(i);
        hit = $onehot(b) && enc == target(m_rodada);
        if (hit && m_acertos < SEQ_LEN) m_acertos++;
        e.acertos = 4'(m_acertos);
        e.jogada  = enc;
        e.estado  = (!hit && m_modo) ? 4'hF : 4'h5;
        sb.push_back(e);
        step(3);
        e = sb.pop_front();
        checks++;
        if (io.acertos !== e.acertos) begin errors++; $display("FAIL press_acertos: got %0d required %0d", io.acertos, e.acertos); end
        checks++;
        if (io.db_jogada !== e.jogada) begin errors++; $display("FAIL press_jogada: got %0d required %0d", io.db_jogada, e.jogada); end
        checks++;
        if (io.db_estado !== e.estado) begin errors++; $display("FAIL press_estado: got %h required %h", io.db_estado, e.estado); end
        if (e.estado == 4'h5 && m_rodada < SEQ_LEN - 1) m_rodada++;
        if (!hold) io.botoes = '0;
    endtask

    task automatic test_reset;
        io.iniciar = 1'b0;
        io.modo    = 1'b0;
        io.botoes  = '0;
        reset      = 1'b0;
        step(2);
        reset  = 1'b1;
        m_lfsr = 8'hA5;
        checks++;
        if (io.acertos !== 4'd0) begin errors++; $display("FAIL reset_acertos: got %0d required 0", io.acertos); end
        checks++;
        if (io.pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto: got %b required 0", io.pronto); end
        checks++;
        if (io.db_estado !== 4'h0) begin errors++; $display("FAIL reset_estado: got %h required 0", io.db_estado); end
        checks++;
        if (io.indices !== '0) begin errors++; $display("FAIL reset_indices: got %h required 0", io.indices); end
    endtask

    task automatic play_all_hits;
        for (int k = 0; k < SEQ_LEN; k++) press(onehot_of(target(k)), 1'b0);
        checks++;
        if (io.pronto !== 1'b0) begin errors++; $display("FAIL pronto_early: got %b required 0", io.pronto); end
        step();
        checks++;
        if (io.pronto !== 1'b1) begin errors++; $display("FAIL pronto_all: got %b required 1", io.pronto); end
        checks++;
        if (io.db_estado !== 4'hF) begin errors++; $display("FAIL fim_estado: got %h required F", io.db_estado); end
        checks++;
        if (io.acertos !== 4'(SEQ_LEN)) begin errors++; $display("FAIL all_acertos: got %0d required %0d", io.acertos, SEQ_LEN); end
    endtask

    task automatic test_all_hits;
        start_game(1'b0);
        play_all_hits();
    endtask

    task automatic test_mixed;
        logic [SEQ_LEN*IDX_W-1:0] prev;
        prev = m_idx;
        start_game(1'b0);
        checks++;
        if (io.indices === prev) begin errors++; $display("FAIL mixed_new_seq: got %h required differ from %h", io.indices, prev); end
        press(onehot_of(target(0)), 1'b0);
        press(onehot_of(IDX_W'(target(1) + 1'b1)), 1'b0);
        press(onehot_of(target(2)), 1'b0);
        press(4'b0011, 1'b0);
        step();
        checks++;
        if (io.pronto !== 1'b1) begin errors++; $display("FAIL mixed_pronto: got %b required 1", io.pronto); end
        checks++;
        if (io.acertos !== 4'd2) begin errors++; $display("FAIL mixed_acertos: got %0d required 2", io.acertos); end
        checks++;
        if (io.rodada !== 4'd3) begin errors++; $display("FAIL mixed_rodada: got %0d required 3", io.rodada); end
    endtask

    task automatic test_sudden_death;
        start_game(1'b1);
        press(onehot_of(target(0)), 1'b0);
        press(onehot_of(IDX_W'(target(1) + 1'b1)), 1'b0);
        checks++;
        if (io.pronto !== 1'b1) begin errors++; $display("FAIL sd_pronto: got %b required 1", io.pronto); end
        step(10);
        checks++;
        if (io.db_estado !== 4'hF) begin errors++; $display("FAIL sd_hold_fim: got %h required F", io.db_estado); end
        checks++;
        if (io.acertos !== 4'd1) begin errors++; $display("FAIL sd_acertos: got %0d required 1", io.acertos); end
        checks++;
        if (io.rodada !== 4'd1) begin errors++; $display("FAIL sd_rodada: got %0d required 1", io.rodada); end
    endtask

    task automatic test_timeout;
        int pulses = 0;
        int at = 0;
        start_game(1'b0);
        for (int i = 1; i <= TIMEOUT + 5; i++) begin
            step();
            if (io.db_timeout === 1'b1) begin
                pulses++;
                at = i;
            end
        end
        m_rodada = 1;
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL timeout_pulses: got %0d required 1", pulses); end
        checks++;
        if (at != TIMEOUT) begin errors++; $display("FAIL timeout_cycle: got %0d required %0d", at, TIMEOUT); end
        checks++;
        if (io.rodada !== 4'd1) begin errors++; $display("FAIL timeout_rodada: got %0d required 1", io.rodada); end
        checks++;
        if (io.acertos !== 4'd0) begin errors++; $display("FAIL timeout_acertos: got %0d required 0", io.acertos); end
        checks++;
        if (io.db_estado !== 4'h2) begin errors++; $display("FAIL timeout_back: got %h required 2", io.db_estado); end
        press(onehot_of(target(1)), 1'b1);
        step(20);
        checks++;
        if (io.db_estado !== 4'h6) begin errors++; $display("FAIL hold_solta: got %h required 6", io.db_estado); end
        checks++;
        if (io.rodada !== 4'd2) begin errors++; $display("FAIL hold_rodada: got %0d required 2", io.rodada); end
        checks++;
        if (io.acertos !== 4'd1) begin errors++; $display("FAIL hold_acertos: got %0d required 1", io.acertos); end
        io.botoes = '0;
        step();
        checks++;
        if (io.db_estado !== 4'h2) begin errors++; $display("FAIL release_espera: got %h required 2", io.db_estado); end
    endtask

    task automatic test_reset_mid;
        reset = 1'b0;
        step();
        reset  = 1'b1;
        m_lfsr = 8'hA5;
        checks++;
        if ({io.pronto, io.acertos, io.rodada, io.indices, io.db_jogada, io.db_timeout, io.db_estado} !== '0) begin
            errors++;
            $display("FAIL reset_mid: estado=%h acertos=%0d rodada=%0d indices=%h required all 0",
                     io.db_estado, io.acertos, io.rodada, io.indices);
        end
    endtask

    task automatic test_back_to_back;
        logic [SEQ_LEN*IDX_W-1:0] prev;
        start_game(1'b0);
        play_all_hits();
        prev = m_idx;
        start_game(1'b0);
        checks++;
        if (io.indices === prev) begin errors++; $display("FAIL b2b_new_seq: got %h required differ from %h", io.indices, prev); end
        checks++;
        if (io.rodada !== 4'd0) begin errors++; $display("FAIL b2b_rodada: got %0d required 0", io.rodada); end
    endtask

    initial begin
        test_reset();
        test_all_hits();
        test_mixed();
        test_sudden_death();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
